// File: rtl/alu_pipe_pkg.sv
// Shared types, command codes and operand-requirement decode for the pipelined ALU.
package alu_pipe_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, MUL} state_t;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_ADD_CIN = 4'd2, A_SUB_CIN = 4'd3;
  localparam logic [3:0] A_INC_A = 4'd4, A_DEC_A = 4'd5, A_INC_B = 4'd6, A_DEC_B = 4'd7;
  localparam logic [3:0] A_CMP = 4'd8, A_MUL_INC = 4'd9, A_MUL_SHL = 4'd10;

  localparam logic [3:0] L_AND = 4'd0, L_NAND = 4'd1, L_OR = 4'd2, L_NOR = 4'd3;
  localparam logic [3:0] L_XOR = 4'd4, L_XNOR = 4'd5, L_NOT_A = 4'd6, L_NOT_B = 4'd7;
  localparam logic [3:0] L_SHR1_A = 4'd8, L_SHL1_A = 4'd9, L_SHR1_B = 4'd10, L_SHL1_B = 4'd11;
  localparam logic [3:0] L_ROL_A_B = 4'd12, L_ROR_A_B = 4'd13;

  // Required inp_valid mask; 00 marks an unknown command.
  function automatic logic [1:0] cmd_needs(input logic mode, input logic [3:0] cmd);
    logic [1:0] r;
    r = 2'b00;
    if (mode) begin
      case (cmd)
        A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_CMP, A_MUL_INC, A_MUL_SHL: r = 2'b11;
        A_INC_A, A_DEC_A: r = 2'b01;
        A_INC_B, A_DEC_B: r = 2'b10;
        default: r = 2'b00;
      endcase
    end else begin
      case (cmd)
        L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR, L_ROL_A_B, L_ROR_A_B: r = 2'b11;
        L_NOT_A, L_SHR1_A, L_SHL1_A: r = 2'b01;
        L_NOT_B, L_SHR1_B, L_SHL1_B: r = 2'b10;
        default: r = 2'b00;
      endcase
    end
    return r;
  endfunction

  function automatic logic is_mul(input logic mode, input logic [3:0] cmd);
    return mode && (cmd == A_MUL_INC || cmd == A_MUL_SHL);
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Command/result bundle between the ALU driver side and the result monitor.
interface alu_pipe_if #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4
);
  logic                   ce, mode, cin;
  logic [1:0]             inp_valid;
  logic [CMD_WIDTH-1:0]   cmd;
  logic [WIDTH-1:0]       opa, opb;
  logic [2*WIDTH-1:0]     res;
  logic                   res_valid, busy, cout, oflow, g, l, e, err;

  modport master (
    output ce, mode, cin, inp_valid, cmd, opa, opb,
    input  res, res_valid, busy, cout, oflow, g, l, e, err
  );
  modport slave (
    input  ce, mode, cin, inp_valid, cmd, opa, opb,
    output res, res_valid, busy, cout, oflow, g, l, e, err
  );
endinterface

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: result and status flags from the latched command and operands.
module alu_pipe_core import alu_pipe_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic               mode,
  input  logic               cin,
  input  logic               bad,
  input  logic [3:0]         cmd,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] res,
  output logic               cout,
  output logic               oflow,
  output logic               g,
  output logic               l,
  output logic               e,
  output logic               err
);
  localparam int SW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;

  logic [WIDTH:0]     ax, bx, cx, one, ash, t;
  logic [PW-1:0]      p_inc, p_shl;
  logic [SW-1:0]      sh;
  logic               sh_bad;
  logic [WIDTH-1:0]   rol, ror;

  assign ax  = {1'b0, a};
  assign bx  = {1'b0, b};
  assign cx  = {{WIDTH{1'b0}}, cin};
  assign one = {{WIDTH{1'b0}}, 1'b1};
  assign ash = {a, 1'b0};
  // Both multiply terms are WIDTH+1 bits; the product is truncated to 2*WIDTH.
  assign p_inc = PW'(ax + one) * PW'(bx + one);
  assign p_shl = PW'(ash) * PW'(b);

  assign sh     = b[SW-1:0];
  assign sh_bad = (b >> SW) != '0;
  assign rol    = (a << sh) | (a >> (WIDTH - int'(sh)));
  assign ror    = (a >> sh) | (a << (WIDTH - int'(sh)));

  always_comb begin
    res = '0; cout = 1'b0; oflow = 1'b0; g = 1'b0; l = 1'b0; e = 1'b0; err = 1'b0;
    t = '0;
    if (bad) begin
      err = 1'b1;
    end else if (mode) begin
      case (cmd)
        A_ADD:     begin t = ax + bx;      res = {{(WIDTH-1){1'b0}}, t}; cout = t[WIDTH]; end
        A_ADD_CIN: begin t = ax + bx + cx; res = {{(WIDTH-1){1'b0}}, t}; cout = t[WIDTH]; end
        A_INC_A:   begin t = ax + one;     res = {{(WIDTH-1){1'b0}}, t}; cout = t[WIDTH]; end
        A_INC_B:   begin t = bx + one;     res = {{(WIDTH-1){1'b0}}, t}; cout = t[WIDTH]; end
        A_SUB:     begin t = ax - bx;      res = {{WIDTH{1'b0}}, t[WIDTH-1:0]}; oflow = t[WIDTH]; end
        A_SUB_CIN: begin t = ax - bx - cx; res = {{WIDTH{1'b0}}, t[WIDTH-1:0]}; oflow = t[WIDTH]; end
        A_DEC_A:   begin t = ax - one;     res = {{WIDTH{1'b0}}, t[WIDTH-1:0]}; oflow = t[WIDTH]; end
        A_DEC_B:   begin t = bx - one;     res = {{WIDTH{1'b0}}, t[WIDTH-1:0]}; oflow = t[WIDTH]; end
        A_CMP:     begin g = a > b; l = a < b; e = a == b; end
        A_MUL_INC: res = p_inc;
        A_MUL_SHL: res = p_shl;
        default:   err = 1'b1;
      endcase
    end else begin
      case (cmd)
        L_AND:     res = {{WIDTH{1'b0}}, a & b};
        L_NAND:    res = {{WIDTH{1'b0}}, ~(a & b)};
        L_OR:      res = {{WIDTH{1'b0}}, a | b};
        L_NOR:     res = {{WIDTH{1'b0}}, ~(a | b)};
        L_XOR:     res = {{WIDTH{1'b0}}, a ^ b};
        L_XNOR:    res = {{WIDTH{1'b0}}, ~(a ^ b)};
        L_NOT_A:   res = {{WIDTH{1'b0}}, ~a};
        L_NOT_B:   res = {{WIDTH{1'b0}}, ~b};
        L_SHR1_A:  res = {{WIDTH{1'b0}}, a >> 1};
        L_SHL1_A:  res = {{WIDTH{1'b0}}, a << 1};
        L_SHR1_B:  res = {{WIDTH{1'b0}}, b >> 1};
        L_SHL1_B:  res = {{WIDTH{1'b0}}, b << 1};
        L_ROL_A_B: if (sh_bad) err = 1'b1; else res = {{WIDTH{1'b0}}, rol};
        L_ROR_A_B: if (sh_bad) err = 1'b1; else res = {{WIDTH{1'b0}}, ror};
        default:   err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU top: operand collection FSM, operand latches, timeout counter and result registers.
module alu_pipe import alu_pipe_pkg::*; #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4,
  parameter int TIMEOUT   = 16
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               go, mode_q, cin_q, bad_q;
  logic [3:0]         cmd_q;
  logic [1:0]         miss_q;
  logic [WIDTH-1:0]   a_q, b_q;

  logic [CMD_WIDTH-1:0] cmd_in;
  logic [3:0]           cmd4;
  logic [1:0]           iv, need;
  logic                 hi_bad, mul_cmd, got;
  logic [2*WIDTH-1:0]   c_res;
  logic                 c_cout, c_oflow, c_g, c_l, c_e, c_err;

  assign cmd_in    = bus.cmd;
  assign cmd4      = cmd_in[3:0];
  assign hi_bad    = (cmd_in >> 4) != '0;
  assign iv        = bus.inp_valid;
  assign need      = hi_bad ? 2'b00 : cmd_needs(bus.mode, cmd4);
  assign mul_cmd   = !hi_bad && is_mul(bus.mode, cmd4);
  assign got       = |(iv & miss_q);
  assign bus.busy  = (state != IDLE);

  alu_pipe_core #(.WIDTH(WIDTH)) u_core (
    .mode(mode_q), .cin(cin_q), .bad(bad_q), .cmd(cmd_q), .a(a_q), .b(b_q),
    .res(c_res), .cout(c_cout), .oflow(c_oflow), .g(c_g), .l(c_l), .e(c_e), .err(c_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE; cnt <= '0; go <= 1'b0;
      mode_q <= 1'b0; cin_q <= 1'b0; bad_q <= 1'b0; cmd_q <= '0; miss_q <= '0;
      a_q <= '0; b_q <= '0;
      bus.res <= '0; bus.res_valid <= 1'b0;
      bus.cout <= 1'b0; bus.oflow <= 1'b0; bus.g <= 1'b0; bus.l <= 1'b0; bus.e <= 1'b0; bus.err <= 1'b0;
    end else begin
      bus.res_valid <= 1'b0;
      if (bus.ce) begin
        go <= 1'b0;
        // go marks operand latches holding a command ready to be written out.
        if (go) begin
          bus.res <= c_res; bus.res_valid <= 1'b1;
          bus.cout <= c_cout; bus.oflow <= c_oflow; bus.g <= c_g; bus.l <= c_l;
          bus.e <= c_e; bus.err <= c_err;
        end
        case (state)
          IDLE: if (iv != 2'b00) begin
            mode_q <= bus.mode; cin_q <= bus.cin; cmd_q <= cmd4;
            a_q <= bus.opa; b_q <= bus.opb;
            bad_q <= hi_bad || (need != 2'b11 && (iv & need) != need);
            if (need == 2'b11 && iv != 2'b11) begin
              miss_q <= ~iv; cnt <= '0; state <= WAIT;
            end else if (mul_cmd) begin
              state <= MUL;
            end else begin
              go <= 1'b1;
            end
          end
          WAIT: if (got) begin
            if (miss_q[0]) a_q <= bus.opa;
            if (miss_q[1]) b_q <= bus.opb;
            cnt <= '0;
            if (is_mul(mode_q, cmd_q)) state <= MUL;
            else begin state <= IDLE; go <= 1'b1; end
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            // Last counted cycle passed with no operand: report the timeout directly.
            state <= IDLE; cnt <= '0;
            bus.res <= '0; bus.res_valid <= 1'b1; bus.err <= 1'b1;
            bus.cout <= 1'b0; bus.oflow <= 1'b0; bus.g <= 1'b0; bus.l <= 1'b0; bus.e <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
          MUL: begin state <= IDLE; go <= 1'b1; end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: vector table through a scoreboard plus timing sequences.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int W = 8;
  localparam logic AR = 1'b1, LG = 1'b0;
  localparam logic [5:0] F0 = 6'b000000, FC = 6'b100000, FO = 6'b010000, FG = 6'b001000;
  localparam logic [5:0] FL = 6'b000100, FE = 6'b000010, FX = 6'b000001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W), .CMD_WIDTH(4)) bus ();
  alu_pipe #(.WIDTH(W), .CMD_WIDTH(4), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic mode; logic [3:0] cmd; logic cin; logic [1:0] iv;
    logic [7:0] a, b; logic [15:0] res; logic [5:0] fl;
  } vec_t;
  typedef struct { logic [15:0] res; logic [5:0] fl; string name; } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int total = 0, bad = 0;

  function automatic vec_t mk(input logic m, input logic [3:0] c, input logic ci, input logic [1:0] iv,
                              input logic [7:0] a, input logic [7:0] b, input logic [15:0] r, input logic [5:0] f);
    vec_t v;
    v.mode = m; v.cmd = c; v.cin = ci; v.iv = iv; v.a = a; v.b = b; v.res = r; v.fl = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic push(input string n, input logic [15:0] r, input logic [5:0] f);
    exp_t x;
    x.res = r; x.fl = f; x.name = n;
    sb.push_back(x);
  endtask

  task automatic drive(input logic m, input logic [3:0] c, input logic ci, input logic [1:0] iv,
                       input logic [7:0] a, input logic [7:0] b);
    bus.mode = m; bus.cmd = c; bus.cin = ci; bus.inp_valid = iv; bus.opa = a; bus.opb = b;
  endtask

  function automatic logic [5:0] flags();
    return {bus.cout, bus.oflow, bus.g, bus.l, bus.e, bus.err};
  endfunction

  // Scoreboard: every res_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t x;
    if (rst && bus.res_valid) begin
      if (sb.size() == 0) check("unexpected res_valid", 32'd1, 32'd0);
      else begin
        x = sb.pop_front();
        check({x.name, " res"}, 32'(bus.res), 32'(x.res));
        check({x.name, " flags"}, 32'(flags()), 32'(x.fl));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first;
    bus.ce = 1'b1;
    drive(AR, 4'd0, 1'b0, 2'b00, 8'd0, 8'd0);

    vt.push_back(mk(AR, A_ADD,     0, 2'b11, 8'hFF, 8'h01, 16'h0100, FC));
    vt.push_back(mk(AR, A_ADD,     1, 2'b11, 8'h01, 8'h01, 16'h0002, F0));
    vt.push_back(mk(AR, A_SUB,     0, 2'b11, 8'h03, 8'h05, 16'h00FE, FO));
    vt.push_back(mk(AR, A_SUB,     0, 2'b11, 8'h09, 8'h04, 16'h0005, F0));
    vt.push_back(mk(AR, A_ADD_CIN, 1, 2'b11, 8'd10,  8'd20,  16'd31,   F0));
    vt.push_back(mk(AR, A_SUB_CIN, 1, 2'b11, 8'd10,  8'd3,   16'd6,    F0));
    vt.push_back(mk(AR, A_SUB_CIN, 1, 2'b11, 8'd2,   8'd2,   16'h00FF, FO));
    vt.push_back(mk(AR, A_INC_A,   0, 2'b01, 8'hFF, 8'h00, 16'h0100, FC));
    vt.push_back(mk(AR, A_DEC_A,   0, 2'b01, 8'h00, 8'h33, 16'h00FF, FO));
    vt.push_back(mk(AR, A_INC_B,   0, 2'b10, 8'h50, 8'h07, 16'h0008, F0));
    vt.push_back(mk(AR, A_DEC_B,   0, 2'b10, 8'h50, 8'h01, 16'h0000, F0));
    vt.push_back(mk(AR, A_CMP,     0, 2'b11, 8'd5,  8'd9,  16'h0000, FL));
    vt.push_back(mk(AR, A_CMP,     0, 2'b11, 8'd9,  8'd9,  16'h0000, FE));
    vt.push_back(mk(AR, A_CMP,     0, 2'b11, 8'd10, 8'd3,  16'h0000, FG));
    vt.push_back(mk(AR, A_MUL_INC, 0, 2'b11, 8'hFF, 8'hFF, 16'h0000, F0));
    vt.push_back(mk(AR, A_MUL_INC, 0, 2'b11, 8'd3,  8'd4,  16'd20,   F0));
    vt.push_back(mk(AR, A_MUL_SHL, 0, 2'b11, 8'h80, 8'h03, 16'h0300, F0));
    vt.push_back(mk(AR, A_MUL_SHL, 0, 2'b11, 8'hFF, 8'hFF, 16'hFC02, F0));
    vt.push_back(mk(LG, L_AND,     0, 2'b11, 8'hF0, 8'h3C, 16'h0030, F0));
    vt.push_back(mk(LG, L_NAND,    0, 2'b11, 8'hF0, 8'h3C, 16'h00CF, F0));
    vt.push_back(mk(LG, L_OR,      0, 2'b11, 8'hF0, 8'h3C, 16'h00FC, F0));
    vt.push_back(mk(LG, L_NOR,     0, 2'b11, 8'hF0, 8'h3C, 16'h0003, F0));
    vt.push_back(mk(LG, L_XOR,     0, 2'b11, 8'hF0, 8'h3C, 16'h00CC, F0));
    vt.push_back(mk(LG, L_XNOR,    0, 2'b11, 8'hF0, 8'h3C, 16'h0033, F0));
    vt.push_back(mk(LG, L_NOT_A,   0, 2'b11, 8'h5A, 8'h00, 16'h00A5, F0));
    vt.push_back(mk(LG, L_NOT_B,   0, 2'b10, 8'h00, 8'h0F, 16'h00F0, F0));
    vt.push_back(mk(LG, L_SHR1_A,  0, 2'b01, 8'h81, 8'h00, 16'h0040, F0));
    vt.push_back(mk(LG, L_SHL1_A,  0, 2'b01, 8'h81, 8'h00, 16'h0002, F0));
    vt.push_back(mk(LG, L_SHR1_B,  0, 2'b10, 8'h00, 8'h02, 16'h0001, F0));
    vt.push_back(mk(LG, L_SHL1_B,  0, 2'b10, 8'h00, 8'h40, 16'h0080, F0));
    vt.push_back(mk(LG, L_ROL_A_B, 0, 2'b11, 8'h81, 8'h01, 16'h0003, F0));
    vt.push_back(mk(LG, L_ROL_A_B, 0, 2'b11, 8'h81, 8'h07, 16'h00C0, F0));
    vt.push_back(mk(LG, L_ROL_A_B, 0, 2'b11, 8'h81, 8'h08, 16'h0000, FX));
    vt.push_back(mk(LG, L_ROR_A_B, 0, 2'b11, 8'h81, 8'h01, 16'h00C0, F0));
    vt.push_back(mk(AR, 4'd11,     0, 2'b11, 8'h12, 8'h34, 16'h0000, FX));
    vt.push_back(mk(LG, 4'd14,     0, 2'b11, 8'h12, 8'h34, 16'h0000, FX));
    vt.push_back(mk(AR, A_INC_A,   0, 2'b10, 8'h12, 8'h34, 16'h0000, FX));
    vt.push_back(mk(LG, L_NOT_B,   0, 2'b01, 8'h12, 8'h34, 16'h0000, FX));

    // Reset state
    @(negedge clk);
    check("reset res", 32'(bus.res), 32'd0);
    check("reset flags", 32'(flags()), 32'd0);
    check("reset res_valid", 32'(bus.res_valid), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].mode, vt[i].cmd, vt[i].cin, vt[i].iv, vt[i].a, vt[i].b);
      push($sformatf("vec%0d", i), vt[i].res, vt[i].fl);
      @(negedge clk);
      bus.inp_valid = 2'b00;
      repeat (3) @(negedge clk);
    end

    // Non-multiply latency and result hold
    @(negedge clk);
    drive(AR, A_ADD, 0, 2'b11, 8'hFF, 8'h01);
    push("add latency", 16'h0100, FC);
    first = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) bus.inp_valid = 2'b00;
      if (first == 0 && bus.res_valid) first = k;
    end
    check("add res_valid cycle", first, 2);
    check("res held", 32'(bus.res), 32'h0100);

    // Multiply latency and busy
    drive(AR, A_MUL_INC, 0, 2'b11, 8'd3, 8'd4);
    push("mul latency", 16'd20, F0);
    first = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin check("mul busy", 32'(bus.busy), 32'd1); bus.inp_valid = 2'b00; end
      if (k == 2) check("mul busy drop", 32'(bus.busy), 32'd0);
      if (first == 0 && bus.res_valid) first = k;
    end
    check("mul res_valid cycle", first, 3);

    // Split ADD: opa now, opb three cycles later; cmd/opa changes during WAIT are ignored
    drive(AR, A_ADD, 0, 2'b01, 8'd5, 8'h77);
    push("wait add", 16'd12, F0);
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k <= 3) check($sformatf("wait busy %0d", k), 32'(bus.busy), 32'd1);
      if (k == 1) drive(AR, A_SUB, 0, 2'b00, 8'hAA, 8'h00);
      if (k == 3) drive(LG, L_XOR, 0, 2'b10, 8'h99, 8'd7);
      if (k == 4) bus.inp_valid = 2'b00;
      if (first == 0 && bus.res_valid) first = k;
    end
    check("wait add res_valid cycle", first, 5);

    // Timeout with no opa
    drive(AR, A_SUB, 0, 2'b10, 8'h00, 8'd3);
    push("timeout", 16'h0000, FX);
    first = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) bus.inp_valid = 2'b00;
      if (first == 0 && bus.res_valid) first = k;
    end
    check("timeout cycle", first, 17);

    // Timeout with one ce=0 cycle in the wait
    drive(AR, A_SUB, 0, 2'b10, 8'h00, 8'd3);
    push("timeout ce", 16'h0000, FX);
    first = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) bus.inp_valid = 2'b00;
      if (k == 5) bus.ce = 1'b0;
      if (k == 6) bus.ce = 1'b1;
      if (first == 0 && bus.res_valid) first = k;
    end
    check("timeout ce cycle", first, 18);

    // Missing operand on the last counted cycle is accepted
    drive(AR, A_SUB, 0, 2'b10, 8'h00, 8'd3);
    push("timeout edge accept", 16'd7, F0);
    first = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) bus.inp_valid = 2'b00;
      if (k == 16) drive(AR, A_SUB, 0, 2'b01, 8'd10, 8'h00);
      if (k == 17) bus.inp_valid = 2'b00;
      if (first == 0 && bus.res_valid) first = k;
    end
    check("timeout edge cycle", first, 18);

    // Reset during MUL aborts without a result
    @(negedge clk);
    drive(AR, A_MUL_INC, 0, 2'b11, 8'd3, 8'd4);
    @(negedge clk);
    bus.inp_valid = 2'b00;
    check("mid-mul busy", 32'(bus.busy), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rst res", 32'(bus.res), 32'd0);
    check("rst flags", 32'(flags()), 32'd0);
    check("rst res_valid", 32'(bus.res_valid), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    drive(AR, A_ADD, 0, 2'b11, 8'd2, 8'd3);
    push("post-reset add", 16'd5, F0);
    first = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) bus.inp_valid = 2'b00;
      if (first == 0 && bus.res_valid) first = k;
    end
    check("post-reset add cycle", first, 2);

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
    check("scoreboard drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
